// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: default sizes, FSM state
// encodings and the operation selector.
package mdu_pkg;

  // Default operand width and the matching iteration-counter width.
  localparam int MDU_WIDTH = 32;
  localparam int MDU_CNTW  = 5;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SIGN = 2'd2
  } mdu_state_e;

  // Operation held in the datapath for the duration of an iteration run.
  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } mdu_op_e;

endpackage

// File: rtl/mdu_datapath.sv
// Iterative multiply/divide datapath.
// Operands are latched as magnitudes; the accumulator pair {acc_hi, acc_lo}
// is shifted once per step. For multiply acc_lo starts as |A| (the multiplier
// bits consumed from the LSB) and mcand holds |B|. For divide acc_lo starts as
// the dividend magnitude, mcand is the divisor magnitude and acc_hi is the
// partial remainder. The sign-corrected results are presented combinationally
// so the controller can capture them in its SIGN cycle.
module mdu_datapath
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             step_i,
  input  mdu_op_e          op_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o
);

  mdu_op_e          op_q,     op_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] a_raw_q,  a_raw_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;

  // Operand sign detection and magnitude conversion at load time.
  logic             sa_in, sb_in;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign sa_in = signed_i & src_a_i[WIDTH-1];
  assign sb_in = signed_i & src_b_i[WIDTH-1];
  assign mag_a = sa_in ? -src_a_i : src_a_i;
  assign mag_b = sb_in ? -src_b_i : src_b_i;

  // One shift-add step: the carry out of the add becomes the new MSB of hi,
  // and the LSB of the sum shifts down into lo.
  logic [WIDTH:0] add_sum;
  assign add_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);

  // One restoring-divide step. The shifted remainder can need WIDTH+1 bits;
  // the subtract borrow (trial MSB) decides the quotient bit.
  logic [WIDTH:0] shifted, trial;
  assign shifted = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, mcand_q};

  // Load / step next-state for the operand and accumulator registers.
  always_comb begin
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_raw_d  = a_raw_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    if (load_i) begin
      op_d     = op_i;
      sign_a_d = sa_in;
      sign_b_d = sb_in;
      a_raw_d  = src_a_i;
      mcand_d  = mag_b;
      acc_hi_d = '0;
      acc_lo_d = mag_a;
    end else if (step_i) begin
      if (op_q == OP_MUL) begin
        acc_hi_d = add_sum[WIDTH:1];
        acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
      end else if (!trial[WIDTH]) begin
        acc_hi_d = trial[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_d = shifted[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      op_q     <= OP_MUL;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_raw_q  <= '0;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
    end else begin
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_raw_q  <= a_raw_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
    end
  end

  // Sign fix-up of the finished accumulators.
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic               div_zero;

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
  assign quot_fix = (sign_a_q ^ sign_b_q) ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = sign_a_q ? -acc_hi_q : acc_hi_q;
  assign div_zero = (mcand_q == '0);

  // Result select; divide-by-zero returns all-ones quotient and the raw
  // dividend as remainder, bypassing sign correction.
  always_comb begin
    res_hi_o = prod_fix[2*WIDTH-1:WIDTH];
    res_lo_o = prod_fix[WIDTH-1:0];
    if (op_q == OP_DIV) begin
      if (div_zero) begin
        res_hi_o = a_raw_q;
        res_lo_o = '1;
      end else begin
        res_hi_o = rem_fix;
        res_lo_o = quot_fix;
      end
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the pipelined core. Owns HI/LO, sequences
// the iterative datapath for WIDTH cycles, and requests a pipeline stall
// while a decode-stage HI/LO access would race an operation in flight.
//
// state | meaning
// IDLE  | no operation; mthi/mtlo writes accepted; start latches operands
// RUN   | one datapath iteration per cycle, counter 0..WIDTH-1
// SIGN  | sign fix-up, result written to HI/LO, back to IDLE
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNTW  = MDU_CNTW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MdStartE,
  input  logic             MdDivE,
  input  logic             MdSignedE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             HiLoAccessD,
  input  logic             HiWriteW,
  input  logic             LoWriteW,
  input  logic [WIDTH-1:0] ResultW,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             MdBusy,
  output logic             StallMD
);

  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CNTW-1:0]  cnt_q,   cnt_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;

  logic             dp_load, dp_step;
  logic [WIDTH-1:0] res_hi,  res_lo;

  assign dp_load = (state_q == ST_IDLE) && MdStartE;
  assign dp_step = (state_q == ST_RUN);

  mdu_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_i   (dp_load),
    .step_i   (dp_step),
    .op_i     (MdDivE ? OP_DIV : OP_MUL),
    .signed_i (MdSignedE),
    .src_a_i  (SrcAE),
    .src_b_i  (SrcBE),
    .res_hi_o (res_hi),
    .res_lo_o (res_lo)
  );

  // Next-state, iteration counter and HI/LO write selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (MdStartE) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
        if (HiWriteW) hi_d = ResultW;
        if (LoWriteW) lo_d = ResultW;
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = ST_SIGN;
      end
      ST_SIGN: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and HI/LO registers; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Busy includes the start cycle itself so the instruction right behind a
  // start is already held off.
  assign MdBusy  = (state_q != ST_IDLE) || MdStartE;
  assign StallMD = MdBusy && HiLoAccessD;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

  // A start while busy would be silently dropped; the hazard unit must
  // never let that happen.
  a_no_start_when_busy : assert property (
    @(posedge clk) disable iff (reset) !(MdStartE && (state_q != ST_IDLE))
  );

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: the stimulus process pushes the expected
// HI/LO/stall profile of each operation; the monitor pops and compares when
// MdBusy falls.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MdStartE, MdDivE, MdSignedE;
  logic [31:0] SrcAE, SrcBE;
  logic        HiLoAccessD, HiWriteW, LoWriteW;
  logic [31:0] ResultW;
  logic [31:0] Hi, Lo;
  logic        MdBusy, StallMD;

  mdu_ctrl #(.WIDTH(32), .CNTW(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .MdStartE    (MdStartE),
    .MdDivE      (MdDivE),
    .MdSignedE   (MdSignedE),
    .SrcAE       (SrcAE),
    .SrcBE       (SrcBE),
    .HiLoAccessD (HiLoAccessD),
    .HiWriteW    (HiWriteW),
    .LoWriteW    (LoWriteW),
    .ResultW     (ResultW),
    .Hi          (Hi),
    .Lo          (Lo),
    .MdBusy      (MdBusy),
    .StallMD     (StallMD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  // Monitor: count busy/stall cycles, compare when an operation completes.
  initial begin : monitor
    int   busy_cnt;
    int   stall_cnt;
    exp_t e;
    busy_cnt  = 0;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (MdBusy === 1'b1) begin
        busy_cnt++;
        if (StallMD === 1'b1) stall_cnt++;
      end else if (busy_cnt != 0) begin
        if (reset !== 1'b1) begin
          if (sb_q.size() == 0) begin
            check("unexpected_completion", 32'(busy_cnt), 32'd0);
          end else begin
            e = sb_q.pop_front();
            check($sformatf("op%0d_hi", e.id), Hi, e.hi);
            check($sformatf("op%0d_lo", e.id), Lo, e.lo);
            check($sformatf("op%0d_busy_cycles", e.id), 32'(busy_cnt), 32'd34);
            check($sformatf("op%0d_stall_cycles", e.id), 32'(stall_cnt), 32'(e.stall));
            check($sformatf("op%0d_stall_after", e.id), {31'd0, StallMD}, 32'd0);
          end
          done_cnt++;
        end
        busy_cnt  = 0;
        stall_cnt = 0;
      end
    end
  end

  task automatic run_op(input logic div, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int stall, input int id);
    exp_t e;
    int   start_done;
    bit   seen;
    @(posedge clk); #2;
    MdStartE  = 1'b1;
    MdDivE    = div;
    MdSignedE = sgn;
    SrcAE     = a;
    SrcBE     = b;
    e.hi = exp_hi; e.lo = exp_lo; e.stall = stall; e.id = id;
    sb_q.push_back(e);
    start_done = done_cnt;
    @(posedge clk); #2;
    MdStartE = 1'b0;
    SrcAE    = 32'hDEAD_BEEF;
    SrcBE    = 32'h0BAD_F00D;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (done_cnt != start_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check($sformatf("op%0d_timeout", id), 32'd0, 32'd1);
  endtask

  initial begin : stim
    reset = 1'b1; MdStartE = 1'b0; MdDivE = 1'b0; MdSignedE = 1'b0;
    SrcAE = '0; SrcBE = '0; HiLoAccessD = 1'b1; HiWriteW = 1'b0;
    LoWriteW = 1'b0; ResultW = '0;

    // Reset state, including stall gating with a decode access present.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hi", Hi, 32'd0);
    check("reset_lo", Lo, 32'd0);
    check("reset_busy", {31'd0, MdBusy}, 32'd0);
    check("reset_stall", {31'd0, StallMD}, 32'd0);
    // Start under reset: combinational busy/stall follow MdStartE, nothing launches.
    @(posedge clk); #2;
    MdStartE = 1'b1; MdSignedE = 1'b0; SrcAE = 32'd9; SrcBE = 32'd9;
    @(negedge clk);
    check("reset_start_busy", {31'd0, MdBusy}, 32'd1);
    check("reset_start_stall", {31'd0, StallMD}, 32'd1);
    @(posedge clk); #2;
    MdStartE = 1'b0;
    @(negedge clk);
    check("reset_start_ignored", {31'd0, MdBusy}, 32'd0);
    @(posedge clk); #2;
    reset = 1'b0; HiLoAccessD = 1'b0;

    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 1);
    HiLoAccessD = 1'b1;
    run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34, 2);
    #2 HiLoAccessD = 1'b0;

    // mthi then mtlo in IDLE.
    @(posedge clk); #2;
    HiWriteW = 1'b1; ResultW = 32'h0000_1234;
    @(posedge clk); #2;
    HiWriteW = 1'b0; ResultW = 32'h0;
    @(negedge clk);
    check("mthi_hi", Hi, 32'h0000_1234);
    check("mthi_lo_kept", Lo, 32'hFFFF_FFEB);
    @(posedge clk); #2;
    LoWriteW = 1'b1; ResultW = 32'h0000_5678;
    @(posedge clk); #2;
    LoWriteW = 1'b0; ResultW = 32'h0;
    @(negedge clk);
    check("mtlo_lo", Lo, 32'h0000_5678);
    check("mtlo_hi_kept", Hi, 32'h0000_1234);

    run_op(1'b1, 1'b0, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 0, 3);
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 4);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 5);
    run_op(1'b1, 1'b0, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 0, 6);
    run_op(1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, 7);
    run_op(1'b0, 1'b1, 32'd5,         32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFE2, 0, 8);
    run_op(1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, 9);
    run_op(1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 0, 10);

    // Abort a divide with reset while the counter sits at 10.
    @(posedge clk); #2;
    HiLoAccessD = 1'b1;
    MdStartE = 1'b1; MdDivE = 1'b1; MdSignedE = 1'b0; SrcAE = 32'd100; SrcBE = 32'd7;
    @(posedge clk); #2;
    MdStartE = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("abort_busy_before", {31'd0, MdBusy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("abort_hi", Hi, 32'd0);
    check("abort_lo", Lo, 32'd0);
    check("abort_busy", {31'd0, MdBusy}, 32'd0);
    check("abort_stall", {31'd0, StallMD}, 32'd0);
    @(posedge clk); #2;
    reset = 1'b0; HiLoAccessD = 1'b0;

    run_op(1'b0, 1'b0, 32'd2, 32'd3, 32'h0000_0000, 32'h0000_0006, 0, 11);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
